// File: rtl/door_lock_sequencer.sv
// Sequencer between keypad front-end and shared password checker: digit forwarding, check
// pulsing, failure counting, door/lockout/entry timers. DOOR_LOCK_ALARM_EN adds a lockout alarm.
module door_lock_sequencer #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned OPEN_CYCLES    = 16,
  parameter int unsigned LOCKOUT_CYCLES = 32,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned ENTRY_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_submit,
  input  logic       chk_unlocked,
  output logic [3:0] chk_key,
  output logic       chk_enter,
  output logic       chk_check,
  output logic       door_open,
  output logic       locked_out,
  output logic       bad_attempt,
  output logic [2:0] fail_count,
  output logic       busy
`ifdef DOOR_LOCK_ALARM_EN
  ,
  input  logic       alarm_ack,
  output logic       alarm
`endif
);

  typedef enum logic [2:0] {
    StIdle, StEntry, StCheck, StEval, StOpen, StFail, StLockout
  } state_e;

  localparam int unsigned CntW   = $clog2(DIGITS + 1);
  localparam int unsigned TMaxA  = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TMax   = (TMaxA > ENTRY_TIMEOUT) ? TMaxA : ENTRY_TIMEOUT;
  localparam int unsigned TimerW = $clog2(TMax + 1);

  localparam logic [CntW-1:0]   DigitsMax = CntW'(DIGITS);
  localparam logic [TimerW-1:0] OpenLast  = TimerW'(OPEN_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast  = TimerW'(LOCKOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] EntryLast = TimerW'(ENTRY_TIMEOUT - 1);
  localparam logic [2:0]        MaxFails  = 3'(MAX_FAILS);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                abandon_q, abandon_d;
  logic [2:0]          fail_q, fail_d;
  logic [3:0]          chk_key_q, chk_key_d;
  logic                chk_enter_q, chk_enter_d;
  logic                chk_check_q, chk_check_d;
  logic                door_open_q, door_open_d;
  logic                locked_out_q, locked_out_d;
  logic                bad_attempt_q, bad_attempt_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    abandon_d   = abandon_q;
    fail_d      = fail_q;
    chk_key_d   = chk_key_q;
    chk_enter_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_valid) begin
          chk_key_d   = key_code;
          chk_enter_d = 1'b1;
          cnt_d       = CntW'(1);
          timer_d     = '0;
          abandon_d   = 1'b0;
          state_d     = StEntry;
        end
      end
      StEntry: begin
        // Submit beats a simultaneous digit; that digit is dropped.
        if (key_submit) begin
          cnt_d   = '0;
          state_d = StCheck;
        end else if (key_valid) begin
          timer_d = '0;
          if (cnt_q < DigitsMax) begin
            chk_key_d   = key_code;
            chk_enter_d = 1'b1;
            cnt_d       = cnt_q + CntW'(1);
          end
        end else if (timer_q == EntryLast) begin
          cnt_d     = '0;
          abandon_d = 1'b1;
          state_d   = StCheck;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StCheck: state_d = StEval;
      StEval: begin
        timer_d = '0;
        if (abandon_q) begin
          abandon_d = 1'b0;
          state_d   = StIdle;
        end else if (chk_unlocked) begin
          fail_d  = '0;
          state_d = StOpen;
        end else if (fail_q + 3'd1 >= MaxFails) begin
          fail_d  = MaxFails;
          state_d = StLockout;
        end else begin
          fail_d  = fail_q + 3'd1;
          state_d = StFail;
        end
      end
      StOpen: begin
        if (timer_q == OpenLast) begin
          timer_d = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StFail: state_d = StIdle;
      StLockout: begin
        if (timer_q == LockLast) begin
          timer_d = '0;
          fail_d  = '0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of the next state so each lines up with its state.
    chk_check_d   = (state_d == StCheck);
    door_open_d   = (state_d == StOpen);
    locked_out_d  = (state_d == StLockout);
    bad_attempt_d = (state_d == StFail) || ((state_d == StLockout) && (state_q != StLockout));
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      timer_q       <= '0;
      abandon_q     <= 1'b0;
      fail_q        <= '0;
      chk_key_q     <= '0;
      chk_enter_q   <= 1'b0;
      chk_check_q   <= 1'b0;
      door_open_q   <= 1'b0;
      locked_out_q  <= 1'b0;
      bad_attempt_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      abandon_q     <= abandon_d;
      fail_q        <= fail_d;
      chk_key_q     <= chk_key_d;
      chk_enter_q   <= chk_enter_d;
      chk_check_q   <= chk_check_d;
      door_open_q   <= door_open_d;
      locked_out_q  <= locked_out_d;
      bad_attempt_q <= bad_attempt_d;
      busy_q        <= busy_d;
    end
  end

`ifdef DOOR_LOCK_ALARM_EN
  logic alarm_q, alarm_d;

  // Setting on lockout entry wins; acknowledge is honoured only outside lockout.
  always_comb begin
    alarm_d = alarm_q;
    if ((state_d == StLockout) && (state_q != StLockout)) begin
      alarm_d = 1'b1;
    end else if (alarm_ack && (state_q != StLockout)) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

  assign chk_key     = chk_key_q;
  assign chk_enter   = chk_enter_q;
  assign chk_check   = chk_check_q;
  assign door_open   = door_open_q;
  assign locked_out  = locked_out_q;
  assign bad_attempt = bad_attempt_q;
  assign fail_count  = fail_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_door_lock_sequencer.sv
// Randomized bench for door_lock_sequencer: behavioural password checker (code 2-2-3-4) plus an
// attempt-level outcome model; optionally exercises the DOOR_LOCK_ALARM_EN alarm.
module tb_door_lock_sequencer;

  localparam int MaxFails = 3;
  localparam int OpenLen  = 16;
  localparam int LockLen  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid, key_submit, chk_unlocked;
  logic [3:0] key_code, chk_key;
  logic       chk_enter, chk_check, door_open, locked_out, bad_attempt, busy;
  logic [2:0] fail_count;
`ifdef DOOR_LOCK_ALARM_EN
  logic       alarm_ack, alarm;
`endif

  door_lock_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_submit   (key_submit),
    .chk_unlocked (chk_unlocked),
    .chk_key      (chk_key),
    .chk_enter    (chk_enter),
    .chk_check    (chk_check),
    .door_open    (door_open),
    .locked_out   (locked_out),
    .bad_attempt  (bad_attempt),
    .fail_count   (fail_count),
    .busy         (busy)
`ifdef DOOR_LOCK_ALARM_EN
    ,
    .alarm_ack    (alarm_ack),
    .alarm        (alarm)
`endif
  );

  always #5 clk = ~clk;

  // Password checker: stores up to four digits, registered compare on check.
  logic [3:0] cs [4];
  int         cs_n;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n         <= 0;
      chk_unlocked <= 1'b0;
    end else if (chk_check) begin
      chk_unlocked <= (cs_n == 4) && (cs[0] == 4'd2) && (cs[1] == 4'd2) &&
                      (cs[2] == 4'd3) && (cs[3] == 4'd4);
      cs_n         <= 0;
    end else if (chk_enter && cs_n < 4) begin
      cs[cs_n[1:0]] <= chk_key;
      cs_n          <= cs_n + 1;
    end
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         fails = 0;
  int         check_cnt, door_cnt, locked_cnt, bad_cnt, overlap_cnt;
  logic [3:0] enter_q [$];
  logic [3:0] digs [6];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and record what the DUT is driving there.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      if (chk_enter) enter_q.push_back(chk_key);
      if (chk_check) check_cnt++;
      if (chk_enter && chk_check) overlap_cnt++;
      if (door_open) door_cnt++;
      if (locked_out) locked_cnt++;
      if (bad_attempt) bad_cnt++;
    end
  endtask

  task automatic run_attempt(input int n, input bit merge, input bit abandon, input bit rst_open);
    int eff, fwd, k;
    bit open, lock;
    enter_q.delete();
    check_cnt = 0; door_cnt = 0; locked_cnt = 0; bad_cnt = 0;
    eff  = merge ? n - 1 : n;
    fwd  = (eff > 4) ? 4 : eff;
    open = (fwd == 4) && digs[0] == 4'd2 && digs[1] == 4'd2 && digs[2] == 4'd3 &&
           digs[3] == 4'd4;

    for (int i = 0; i < n; i++) begin
      key_valid  = 1'b1;
      key_code   = digs[i];
      key_submit = merge && (i == n - 1);
      step();
      key_valid  = 1'b0;
      key_submit = 1'b0;
      if (i != n - 1) repeat ($urandom_range(0, 2)) step();
    end

    if (abandon) begin
      k = 0;
      while (busy && k < 150) begin
        step();
        k++;
      end
      check_eq("abandon_idle", int'(busy), 0);
      check_eq("abandon_checks", check_cnt, 1);
      check_eq("abandon_bad", bad_cnt, 0);
      check_eq("abandon_door", door_cnt, 0);
      check_eq("abandon_fails", int'(fail_count), fails);
      check_eq("abandon_enters", enter_q.size(), fwd);
      return;
    end

    if (!merge) begin
      key_submit = 1'b1;
      step();
      key_submit = 1'b0;
    end
    check_eq("check_pulse", int'(chk_check), 1);
    check_eq("enter_with_check", int'(chk_enter), 0);
    step();
    check_eq("eval_quiet", int'(door_open | bad_attempt), 0);
    if (open) fails = 0;
    else fails++;
    lock = !open && (fails == MaxFails);
    step();
    check_eq("door_latency", int'(door_open), int'(open));
    check_eq("bad_latency", int'(bad_attempt), int'(!open));
    check_eq("lock_latency", int'(locked_out), int'(lock));
    check_eq("fail_count_eval", int'(fail_count), fails);
`ifdef DOOR_LOCK_ALARM_EN
    if (lock) check_eq("alarm_set", int'(alarm), 1);
`endif

    if (rst_open) begin
      repeat (5) step();
      #2 rst = 1'b1;
      #1;
      check_eq("rst_door", int'(door_open), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_fail_count", int'(fail_count), 0);
      step();
      rst   = 1'b0;
      fails = 0;
      return;
    end

    if (lock) fails = 0;
    k = 0;
    while (busy && k < 100) begin
      if (door_open || locked_out) begin
        key_valid  = 1'($urandom);
        key_code   = 4'($urandom);
        key_submit = 1'($urandom);
      end
`ifdef DOOR_LOCK_ALARM_EN
      alarm_ack = locked_out;
`endif
      step();
      key_valid  = 1'b0;
      key_submit = 1'b0;
`ifdef DOOR_LOCK_ALARM_EN
      alarm_ack = 1'b0;
`endif
      k++;
    end
    check_eq("return_idle", int'(busy), 0);
    check_eq("enter_count", enter_q.size(), fwd);
    for (int i = 0; i < fwd && i < enter_q.size(); i++) begin
      check_eq("enter_digit", int'(enter_q[i]), int'(digs[i]));
    end
    check_eq("check_count", check_cnt, 1);
    check_eq("door_cycles", door_cnt, open ? OpenLen : 0);
    check_eq("lock_cycles", locked_cnt, lock ? LockLen : 0);
    check_eq("bad_pulses", bad_cnt, open ? 0 : 1);
    check_eq("fail_count_end", int'(fail_count), fails);
`ifdef DOOR_LOCK_ALARM_EN
    if (lock) begin
      check_eq("alarm_held", int'(alarm), 1);
      alarm_ack = 1'b1;
      step();
      alarm_ack = 1'b0;
      check_eq("alarm_cleared", int'(alarm), 0);
    end
`endif
  endtask

  task automatic set_digs(input int a, input int b, input int c, input int d, input int e,
                          input int f);
    digs[0] = 4'(a); digs[1] = 4'(b); digs[2] = 4'(c);
    digs[3] = 4'(d); digs[4] = 4'(e); digs[5] = 4'(f);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n, r;
    bit merge, abandon;
    rst = 1'b1; key_valid = 1'b0; key_submit = 1'b0; key_code = '0;
`ifdef DOOR_LOCK_ALARM_EN
    alarm_ack = 1'b0;
`endif
    overlap_cnt = 0;
    repeat (2) step();
    check_eq("reset_enter", int'(chk_enter), 0);
    check_eq("reset_check", int'(chk_check), 0);
    check_eq("reset_door", int'(door_open), 0);
    check_eq("reset_lock", int'(locked_out), 0);
    check_eq("reset_bad", int'(bad_attempt), 0);
    check_eq("reset_fail_count", int'(fail_count), 0);
    check_eq("reset_busy", int'(busy), 0);
    rst = 1'b0;
    step();

    set_digs(2, 2, 3, 4, 0, 0);
    run_attempt(4, 1'b0, 1'b0, 1'b0);
    set_digs(1, 1, 1, 1, 0, 0);
    repeat (3) run_attempt(4, 1'b0, 1'b0, 1'b0);
    repeat (2) run_attempt(4, 1'b0, 1'b0, 1'b0);
    set_digs(2, 2, 3, 4, 9, 9);
    run_attempt(4, 1'b0, 1'b0, 1'b0);
    run_attempt(6, 1'b0, 1'b0, 1'b0);
    set_digs(2, 2, 0, 0, 0, 0);
    run_attempt(2, 1'b0, 1'b1, 1'b0);
    set_digs(2, 2, 3, 4, 0, 0);
    run_attempt(4, 1'b1, 1'b0, 1'b0);
    run_attempt(4, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        n = 4 + $urandom_range(0, 2);
        set_digs(2, 2, 3, 4, $urandom_range(0, 15), $urandom_range(0, 15));
      end else begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < 6; i++) digs[i] = 4'($urandom_range(0, 15));
      end
      merge   = (n >= 2) && ($urandom_range(0, 9) < 2);
      abandon = !merge && ($urandom_range(0, 9) == 0);
      run_attempt(n, merge, abandon, 1'b0);
    end

    check_eq("enter_check_overlap", overlap_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
